// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 to Hack KBD decoder: Hack key codes,
// scancode set 2 prefix/modifier bytes and decoder FSM states.
package hack_kbd_pkg;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F12       = 8'd152;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational scancode set 2 -> Hack key code lookup (0 = unmapped).
// Letters follow i_upper; digits and punctuation follow i_shift.
module ps2_scancode_map
    import hack_kbd_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_upper,
    output logic [7:0] o_key
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic [7:0] w_fix;
    logic       w_letter;

    always_comb begin
        w_lo  = 8'd0;
        w_hi  = 8'd0;
        w_fix = 8'd0;
        if (i_ext) begin
            case (i_code)
                8'h5A:   w_fix = KEY_NEWLINE;
                8'h6B:   w_fix = KEY_LEFT;
                8'h75:   w_fix = KEY_UP;
                8'h74:   w_fix = KEY_RIGHT;
                8'h72:   w_fix = KEY_DOWN;
                8'h6C:   w_fix = KEY_HOME;
                8'h69:   w_fix = KEY_END;
                8'h7D:   w_fix = KEY_PGUP;
                8'h7A:   w_fix = KEY_PGDN;
                8'h70:   w_fix = KEY_INSERT;
                8'h71:   w_fix = KEY_DELETE;
                default: w_fix = 8'd0;
            endcase
        end else begin
            case (i_code)
                8'h1C: w_lo = "a";
                8'h32: w_lo = "b";
                8'h21: w_lo = "c";
                8'h23: w_lo = "d";
                8'h24: w_lo = "e";
                8'h2B: w_lo = "f";
                8'h34: w_lo = "g";
                8'h33: w_lo = "h";
                8'h43: w_lo = "i";
                8'h3B: w_lo = "j";
                8'h42: w_lo = "k";
                8'h4B: w_lo = "l";
                8'h3A: w_lo = "m";
                8'h31: w_lo = "n";
                8'h44: w_lo = "o";
                8'h4D: w_lo = "p";
                8'h15: w_lo = "q";
                8'h2D: w_lo = "r";
                8'h1B: w_lo = "s";
                8'h2C: w_lo = "t";
                8'h3C: w_lo = "u";
                8'h2A: w_lo = "v";
                8'h1D: w_lo = "w";
                8'h22: w_lo = "x";
                8'h35: w_lo = "y";
                8'h1A: w_lo = "z";
                8'h16: {w_lo, w_hi} = {"1", "!"};
                8'h1E: {w_lo, w_hi} = {"2", "@"};
                8'h26: {w_lo, w_hi} = {"3", "#"};
                8'h25: {w_lo, w_hi} = {"4", "$"};
                8'h2E: {w_lo, w_hi} = {"5", "%"};
                8'h36: {w_lo, w_hi} = {"6", "^"};
                8'h3D: {w_lo, w_hi} = {"7", "&"};
                8'h3E: {w_lo, w_hi} = {"8", "*"};
                8'h46: {w_lo, w_hi} = {"9", "("};
                8'h45: {w_lo, w_hi} = {"0", ")"};
                8'h0E: {w_lo, w_hi} = {8'h60, "~"};
                8'h4E: {w_lo, w_hi} = {"-", "_"};
                8'h55: {w_lo, w_hi} = {"=", "+"};
                8'h54: {w_lo, w_hi} = {"[", "{"};
                8'h5B: {w_lo, w_hi} = {"]", "}"};
                8'h5D: {w_lo, w_hi} = {"\\", "|"};
                8'h4C: {w_lo, w_hi} = {";", ":"};
                8'h52: {w_lo, w_hi} = {"'", "\""};
                8'h41: {w_lo, w_hi} = {",", "<"};
                8'h49: {w_lo, w_hi} = {".", ">"};
                8'h4A: {w_lo, w_hi} = {"/", "?"};
                8'h29: {w_lo, w_hi} = {" ", " "};
                8'h5A: w_fix = KEY_NEWLINE;
                8'h66: w_fix = KEY_BACKSPACE;
                8'h76: w_fix = KEY_ESC;
                8'h05: w_fix = KEY_F1;
                8'h06: w_fix = KEY_F1 + 8'd1;
                8'h04: w_fix = KEY_F1 + 8'd2;
                8'h0C: w_fix = KEY_F1 + 8'd3;
                8'h03: w_fix = KEY_F1 + 8'd4;
                8'h0B: w_fix = KEY_F1 + 8'd5;
                8'h83: w_fix = KEY_F1 + 8'd6;
                8'h0A: w_fix = KEY_F1 + 8'd7;
                8'h01: w_fix = KEY_F1 + 8'd8;
                8'h09: w_fix = KEY_F1 + 8'd9;
                8'h78: w_fix = KEY_F1 + 8'd10;
                8'h07: w_fix = KEY_F12;
                default: w_fix = 8'd0;
            endcase
        end
    end

    assign w_letter = (w_lo >= "a") && (w_lo <= "z");

    always_comb begin
        o_key = w_fix;
        if (w_letter)
            o_key = i_upper ? (w_lo - 8'd32) : w_lo;
        else if (w_lo != 8'd0)
            o_key = i_shift ? w_hi : w_lo;
    end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 scancode set 2 decoder driving the Hack KBD word.
// Caps lock support is built only when PS2_CAPS_LOCK_EN is defined.
module ps2_keyboard_decoder
    import hack_kbd_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 24000,
    parameter int PAUSE_LEN      = 7
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scancode,
    input  logic        scancode_idle,
    output logic [15:0] key,
    output logic        key_strobe,
    output logic        shift,
    output logic        caps_lock
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam int SW = $clog2(PAUSE_LEN + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_idle_q;
    logic [TW-1:0]   r_timer;
    logic [SW-1:0]   r_skip;
    logic            r_lshift;
    logic            r_rshift;
    logic [8:0]      r_held;
    logic [7:0]      r_key;
    logic            r_strobe;

    logic            w_evt;
    logic            w_make;
    logic            w_brk;
    logic            w_ext;
    logic            w_timeout;
    logic            w_shift;
    logic            w_caps;
    logic            w_prefix;
    logic [7:0]      w_map;
    logic [7:0]      w_key_nxt;
    logic [8:0]      w_held_nxt;
    logic [8:0]      w_tag;

    assign w_evt     = ~r_idle_q & scancode_idle;
    assign w_shift   = r_lshift | r_rshift;
    assign w_timeout = (r_state != S_IDLE) && (r_timer == TW'(PREFIX_TIMEOUT));
    assign w_prefix  = (scancode == SC_EXT) || (scancode == SC_BREAK) ||
                       (scancode == SC_PAUSE);
    assign w_tag     = {w_ext, scancode};

    ps2_scancode_map u_map (
        .i_ext   (w_ext),
        .i_code  (scancode),
        .i_shift (w_shift),
        .i_upper (w_shift ^ w_caps),
        .o_key   (w_map)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (w_evt) begin
            case (r_state)
                S_IDLE: begin
                    if (scancode == SC_EXT)        w_state_nxt = S_EXT;
                    else if (scancode == SC_BREAK) w_state_nxt = S_BRK;
                    else if (scancode == SC_PAUSE) w_state_nxt = S_SKIP;
                    else                           w_make = 1'b1;
                end
                S_EXT: begin
                    w_ext = 1'b1;
                    if (scancode == SC_BREAK) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_make = !w_prefix;
                    end
                end
                S_BRK: begin
                    w_state_nxt = S_IDLE;
                    w_brk = !w_prefix;
                end
                S_EXT_BRK: begin
                    w_ext = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_brk = !w_prefix;
                end
                S_SKIP: begin
                    if (r_skip <= SW'(1)) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Typematic repeats of the held key must leave key untouched.
    always_comb begin
        w_key_nxt  = r_key;
        w_held_nxt = r_held;
        if (w_make && (w_map != 8'd0) && (w_tag != r_held)) begin
            w_key_nxt  = w_map;
            w_held_nxt = w_tag;
        end else if (w_brk && (w_tag == r_held)) begin
            w_key_nxt  = 8'd0;
            w_held_nxt = 9'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idle_q <= 1'b1;
            r_key    <= 8'd0;
            r_held   <= 9'd0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idle_q <= scancode_idle;
            r_key    <= w_key_nxt;
            r_held   <= w_held_nxt;
            r_strobe <= (w_key_nxt != r_key);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_skip  <= '0;
        end else begin
            if (w_evt || (r_state == S_IDLE))
                r_timer <= '0;
            else if (!w_timeout)
                r_timer <= r_timer + TW'(1);
            if (w_evt && (r_state == S_IDLE) && (scancode == SC_PAUSE))
                r_skip <= SW'(PAUSE_LEN);
            else if (w_evt && (r_state == S_SKIP))
                r_skip <= r_skip - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
        end else if ((w_make || w_brk) && !w_ext) begin
            if (scancode == SC_LSHIFT) r_lshift <= w_make;
            if (scancode == SC_RSHIFT) r_rshift <= w_make;
        end
    end

`ifdef PS2_CAPS_LOCK_EN
    logic r_caps;
    logic r_caps_held;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (!w_ext && (scancode == SC_CAPS)) begin
            if (w_make && !r_caps_held) begin
                r_caps      <= ~r_caps;
                r_caps_held <= 1'b1;
            end else if (w_brk) begin
                r_caps_held <= 1'b0;
            end
        end
    end

    assign w_caps = r_caps;
`else
    assign w_caps = 1'b0;
`endif

    assign key        = {8'h00, r_key};
    assign key_strobe = r_strobe;
    assign shift      = w_shift;
    assign caps_lock  = w_caps;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed self-checking bench for ps2_keyboard_decoder.
// Caps-lock steps run only when PS2_CAPS_LOCK_EN is defined.
module tb_ps2_keyboard_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  scancode;
    logic        scancode_idle;
    logic [15:0] key;
    logic        key_strobe;
    logic        shift;
    logic        caps_lock;

    int checks = 0;
    int errors = 0;
    int n_strb = 0;
    int s0;

    ps2_keyboard_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .scancode      (scancode),
        .scancode_idle (scancode_idle),
        .key           (key),
        .key_strobe    (key_strobe),
        .shift         (shift),
        .caps_lock     (caps_lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (key_strobe === 1'b1) n_strb++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scancode      = b;
        scancode_idle = 1'b0;
        @(negedge clk);
        scancode_idle = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        scancode      = 8'h00;
        scancode_idle = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_key", int'(key), 0);
        check("rst_strobe", int'(key_strobe), 0);
        check("rst_shift", int'(shift), 0);
        check("rst_caps", int'(caps_lock), 0);

        s0 = n_strb;
        send(8'h1C);
        check("make_a", int'(key), 97);
        check("make_a_strb", n_strb - s0, 1);
        send(8'hF0); send(8'h1C);
        check("brk_a", int'(key), 0);
        check("brk_a_strb", n_strb - s0, 2);

        s0 = n_strb;
        send(8'h1C); send(8'h1C);
        check("rep_a", int'(key), 97);
        check("rep_a_strb", n_strb - s0, 1);
        send(8'hF0); send(8'h1C);

        send(8'h12); send(8'h1C);
        check("shift_A", int'(key), 65);
        check("shift_on", int'(shift), 1);
        send(8'hF0); send(8'h12);
        check("shift_rel_key", int'(key), 65);
        check("shift_off", int'(shift), 0);
        send(8'hF0); send(8'h1C);
        check("brk_A", int'(key), 0);
        send(8'h16);
        check("digit_1", int'(key), 49);
        send(8'hF0); send(8'h16);

        send(8'hE0); send(8'h75);
        check("ext_up", int'(key), 131);
        send(8'hF0); send(8'h75);
        check("plain_brk_75", int'(key), 131);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_brk_up", int'(key), 0);
        send(8'h1C); send(8'hF0); send(8'h2B);
        check("other_brk", int'(key), 97);
        send(8'hF0); send(8'h1C);

        s0 = n_strb;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_key", int'(key), 0);
        check("pause_strb", n_strb - s0, 0);
        send(8'h1C);
        check("after_pause", int'(key), 97);
        send(8'hF0); send(8'h1C);

        send(8'h12); send(8'h4E);
        check("shift_under", int'(key), 95);
        send(8'hF0); send(8'h4E); send(8'hF0); send(8'h12);
        send(8'h5A);
        check("enter", int'(key), 128);
        send(8'hF0); send(8'h5A);
        send(8'h05);
        check("f1", int'(key), 141);
        send(8'hF0); send(8'h05);
        send(8'h07);
        check("f12", int'(key), 152);
        send(8'hF0); send(8'h07);
        send(8'h76);
        s0 = n_strb;
        send(8'hAA);
        check("unmapped_key", int'(key), 140);
        check("unmapped_strb", n_strb - s0, 0);
        send(8'hF0); send(8'h76);
        check("esc_brk", int'(key), 0);

        send(8'hE0);
        repeat (100) @(negedge clk);
        send(8'h75);
        check("no_timeout", int'(key), 131);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0);
        repeat (24001) @(negedge clk);
        send(8'h1C);
        check("timeout_a", int'(key), 97);
        send(8'hF0); send(8'h1C);

`ifdef PS2_CAPS_LOCK_EN
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps_on", int'(caps_lock), 1);
        send(8'h1C);
        check("caps_A", int'(key), 65);
        send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h1C);
        check("caps_shift_a", int'(key), 97);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        check("caps_once", int'(caps_lock), 0);
`else
        send(8'h58); send(8'h1C);
        check("nocaps_a", int'(key), 97);
        check("nocaps_flag", int'(caps_lock), 0);
        send(8'hF0); send(8'h1C);
`endif

        send(8'h1C);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_key", int'(key), 0);
        reset = 1'b0;
        send(8'h1C);
        check("post_rst_a", int'(key), 97);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
